// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone arbiter, one outstanding slave transaction
// Optional slave-ack watchdog is built in when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [2:0]  i_m0_sel,
  output logic [31:0] o_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_stall,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [2:0]  i_m1_sel,
  output logic [31:0] o_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_stall,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic [2:0]  o_s_sel,
  input  logic [31:0] i_s_data,
  input  logic        i_s_ack,
  input  logic        i_s_stall,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [2:0]  sel_q, sel_d;

  logic busy;
  logic winner;
  logic accept;
  logic s_done;
  logic fire;
  logic owner_ack;

  // Owner index: 0 = m0, 1 = m1. On contention the master not served last wins.
  always_comb begin
    winner = 1'b0;
    if (i_m0_stb && i_m1_stb) begin
      winner = ~last_q;
    end else if (i_m1_stb) begin
      winner = 1'b1;
    end
  end

  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign accept    = (state_q == S_IDLE) && (i_m0_stb || i_m1_stb);
  assign s_done    = (state_q == S_WAIT) && i_s_ack;
  assign owner_ack = s_done || fire;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (accept) begin
      wd_d = '0;
    end else if (busy && !fire) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // A real slave ack in the final allowed cycle takes priority over the watchdog.
  assign fire = busy && (wd_q >= WD_LAST) && !s_done;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          owner_d = winner;
          addr_d  = winner ? i_m1_addr : i_m0_addr;
          data_d  = winner ? i_m1_data : i_m0_data;
          we_d    = winner ? i_m1_we   : i_m0_we;
          sel_d   = winner ? i_m1_sel  : i_m0_sel;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else if (!i_s_stall) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (owner_ack) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_q resets to m1 so m0 wins a simultaneous first request.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
    end
  end

  assign o_s_stb  = (state_q == S_ISSUE);
  assign o_s_we   = we_q;
  assign o_s_addr = addr_q;
  assign o_s_data = data_q;
  assign o_s_sel  = sel_q;

  assign o_grant   = busy ? {owner_q, ~owner_q} : 2'b00;
  assign o_timeout = fire;

  assign o_m0_ack   = owner_ack && !owner_q;
  assign o_m1_ack   = owner_ack && owner_q;
  assign o_m0_data  = (s_done && !owner_q) ? i_s_data : 32'hFFFF_FFFF;
  assign o_m1_data  = (s_done && owner_q) ? i_s_data : 32'hFFFF_FFFF;
  assign o_m0_stall = busy || !(accept && !winner);
  assign o_m1_stall = busy || !(accept && winner);

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - self-checking bench for wb_arbiter_2m
// Define WB_ARB_TIMEOUT_EN to exercise the watchdog build.
module tb_wb_arbiter_2m;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int  TO       = 4;
  localparam bit  TO_BUILD = 1'b1;
`else
  localparam int  TO       = 255;
  localparam bit  TO_BUILD = 1'b0;
`endif
  localparam int MAX_STALL = TO_BUILD ? 0 : 3;
  localparam int MAX_ACKD  = TO_BUILD ? 1 : 3;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] o_m0_data, o_m1_data, o_s_addr, o_s_data;
  logic        o_m0_ack, o_m0_stall, o_m1_ack, o_m1_stall, o_s_stb, o_s_we, o_timeout;
  logic [2:0]  o_s_sel;
  logic [1:0]  o_grant;
  logic [31:0] i_s_data;
  logic        i_s_ack, i_s_stall;

  logic        m_stb  [2];
  logic        m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [2:0]  m_sel  [2];
  logic [2:0]  sel_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_srv;
  int w_out, lat_out, stb_out;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_addr(m_addr[0]), .i_m0_data(m_data[0]),
    .i_m0_sel(m_sel[0]), .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall),
    .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_addr(m_addr[1]), .i_m1_data(m_data[1]),
    .i_m1_sel(m_sel[1]), .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall),
    .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .o_s_sel(o_s_sel), .i_s_data(i_s_data), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic ack_of(int m);
    return (m == 1) ? o_m1_ack : o_m0_ack;
  endfunction

  function automatic logic [31:0] data_of(int m);
    return (m == 1) ? o_m1_data : o_m0_data;
  endfunction

  function automatic logic stall_of(int m);
    return (m == 1) ? o_m1_stall : o_m0_stall;
  endfunction

  task automatic rand_master(input int m);
    m_addr[m] = $urandom & 32'hFFFF_FFFC;
    m_data[m] = $urandom;
    m_we[m]   = 1'($urandom_range(0, 1));
    m_sel[m]  = sel_codes[$urandom_range(0, 4)];
  endtask

  // One full transaction; the expected winner comes from the round-robin rule and last_srv.
  task automatic run_txn(input bit r0, input bit r1, input int nstall, input int nackd,
                         input logic [31:0] sdata, output int w, output int lat, output int nstb);
    int l, t0;
    if (r0 && r1) w = (last_srv == 1) ? 0 : 1;
    else          w = r0 ? 0 : 1;
    l = 1 - w;
    m_stb[0] = r0;
    m_stb[1] = r1;
    i_s_ack = 1'b0;
    #1;
    chk("idle_grant", {30'd0, o_grant}, 32'd0);
    chk("win_stall", {31'd0, stall_of(w)}, 32'd0);
    chk("lose_stall", {31'd0, stall_of(l)}, 32'd1);
    step();
    t0 = cyc;
    m_stb[0] = 1'b0;
    m_stb[1] = 1'b0;
    nstb = 0;
    for (int i = 0; i <= nstall; i++) begin
      i_s_stall = (i < nstall);
      i_s_ack   = 1'($urandom_range(0, 1));
      #1;
      if (o_s_stb) nstb++;
      chk("issue_addr", o_s_addr, m_addr[w]);
      chk("issue_data", o_s_data, m_data[w]);
      chk("issue_we", {31'd0, o_s_we}, {31'd0, m_we[w]});
      chk("issue_sel", {29'd0, o_s_sel}, {29'd0, m_sel[w]});
      chk("issue_grant", {30'd0, o_grant}, (w == 1) ? 32'd2 : 32'd1);
      chk("issue_noack", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
      step();
    end
    i_s_stall = 1'b0;
    i_s_ack   = 1'b0;
    for (int i = 0; i < nackd; i++) begin
      #1;
      chk("wait_stb", {31'd0, o_s_stb}, 32'd0);
      chk("wait_noack", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
      chk("wait_stall", {30'd0, o_m1_stall, o_m0_stall}, 32'd3);
      step();
    end
    i_s_ack  = 1'b1;
    i_s_data = sdata;
    #1;
    lat = cyc - t0 + 1;
    chk("own_ack", {31'd0, ack_of(w)}, 32'd1);
    chk("own_data", data_of(w), sdata);
    chk("other_ack", {31'd0, ack_of(l)}, 32'd0);
    chk("other_data", data_of(l), 32'hFFFF_FFFF);
    chk("no_timeout", {31'd0, o_timeout}, 32'd0);
    chk("latency", lat, nstall + 2 + nackd);
    step();
    i_s_ack = 1'b0;
    #1;
    chk("done_grant", {30'd0, o_grant}, 32'd0);
    last_srv = w;
  endtask

  initial begin
    int prev_w;
    m_stb[0] = 1'b0; m_stb[1] = 1'b0;
    rand_master(0); rand_master(1);
    i_s_ack = 1'b0; i_s_stall = 1'b0; i_s_data = '0;
    i_reset_n = 1'b0;
    #1;
    chk("rst_grant", {30'd0, o_grant}, 32'd0);
    chk("rst_stb", {31'd0, o_s_stb}, 32'd0);
    chk("rst_acks", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
    chk("rst_m0_data", o_m0_data, 32'hFFFF_FFFF);
    chk("rst_m1_data", o_m1_data, 32'hFFFF_FFFF);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    step(); step();
    i_reset_n = 1'b1;
    last_srv = 1;
    step();

    // m0 read 0x100 word
    m_addr[0] = 32'h100; m_we[0] = 1'b0; m_sel[0] = 3'b010;
    run_txn(1, 0, 0, 1, 32'hDEAD_BEEF, w_out, lat_out, stb_out);
    chk("r30_winner", w_out, 0);
    chk("r30_latency", lat_out, 3);

    // simultaneous request after reset ordering (last_srv is m0 now, so re-reset first)
    i_reset_n = 1'b0; step(); i_reset_n = 1'b1; last_srv = 1; step();
    rand_master(0); rand_master(1);
    run_txn(1, 1, 0, 0, $urandom, w_out, lat_out, stb_out);
    chk("r31_first", w_out, 0);
    run_txn(0, 1, 0, 0, $urandom, w_out, lat_out, stb_out);
    chk("r31_second", w_out, 1);

    // m1 halfword write with stalled slave
    m_addr[1] = 32'h200; m_data[1] = 32'h55AA; m_we[1] = 1'b1; m_sel[1] = 3'b001;
    run_txn(0, 1, TO_BUILD ? 1 : 3, 0, $urandom, w_out, lat_out, stb_out);
    chk("r32_winner", w_out, 1);
    chk("r32_stb_cycles", stb_out, TO_BUILD ? 2 : 4);

    // reset during S_WAIT, late slave ack must be ignored
    rand_master(0);
    m_stb[0] = 1'b1; #1; step(); m_stb[0] = 1'b0;
    i_s_stall = 1'b0; step();
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("r33_rst_grant", {30'd0, o_grant}, 32'd0);
    chk("r33_rst_acks", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
    step();
    i_reset_n = 1'b1;
    i_s_ack = 1'b1;
    #1;
    chk("r33_late_ack", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
    chk("r33_grant", {30'd0, o_grant}, 32'd0);
    step();
    i_s_ack = 1'b0;
    last_srv = 1;
    rand_master(1);
    run_txn(0, 1, 0, 1, 32'h1234_5678, w_out, lat_out, stb_out);
    chk("r33_after", w_out, 1);

    // continuous contention: strict alternation
    prev_w = last_srv;
    for (int i = 0; i < 10; i++) begin
      rand_master(0); rand_master(1);
      run_txn(1, 1, $urandom_range(0, MAX_STALL), $urandom_range(0, MAX_ACKD), $urandom,
              w_out, lat_out, stb_out);
      chk("r35_alternate", w_out, 1 - prev_w);
      prev_w = w_out;
    end

    // random request patterns against the round-robin model
    for (int i = 0; i < 16; i++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      rand_master(0); rand_master(1);
      run_txn(r0, r1, $urandom_range(0, MAX_STALL), $urandom_range(0, MAX_ACKD), $urandom,
              w_out, lat_out, stb_out);
    end

`ifdef WB_ARB_TIMEOUT_EN
    begin
      int k;
      bit seen;
      seen = 1'b0;
      k = 0;
      rand_master(0);
      m_stb[0] = 1'b1; #1; step(); m_stb[0] = 1'b0;
      i_s_ack = 1'b0; i_s_stall = 1'b0;
      for (int j = 1; j <= TO + 2 && !seen; j++) begin
        #1;
        if (o_m0_ack) begin
          seen = 1'b1;
          k = j;
          chk("r34_data", o_m0_data, 32'hFFFF_FFFF);
          chk("r34_timeout", {31'd0, o_timeout}, 32'd1);
        end
        step();
      end
      chk("r34_fired", {31'd0, seen}, 32'd1);
      chk("r34_window", {31'd0, (k >= TO && k <= TO + 1)}, 32'd1);
      #1;
      chk("r34_pulse_end", {31'd0, o_timeout}, 32'd0);
      chk("r34_idle", {30'd0, o_grant}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
